// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Backward-direction pipeline control for the 5-stage core. Looks at the
//   register fields and control bits carried in the IF/ID, ID/EX, EX/MEM and
//   MEM/WB buffers and produces stall / flush / hold / forwarding controls.
//   Handles load-use stalls, taken-branch flushes, data-memory wait freezes
//   (with a sticky timeout flag) and EX operand forwarding. It also keeps
//   saturating stall and flush event counters.
//
// Parameters
//   CNT_W        width of stall_count / flush_count (saturating)
//   MEM_TIMEOUT  consecutive wait cycles before mem_timeout is raised (>=1)
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   ifid_rs1/ifid_rs2          source fields of the instruction in IF/ID
//   idex_rs1/rs2/rd, memread   ID/EX register fields and MemRead
//   exmem_rd/regwrite/memread/memwrite   EX/MEM destination and controls
//   memwb_rd/regwrite          MEM/WB destination and RegWrite
//   branch_taken               EX-stage branch/jump resolved taken
//   mem_ready                  data memory completes its access this cycle
//   pc_write, ifid_write       PC and IF/ID load enables
//   ifid_flush, idex_flush     clear IF/ID to NOP, ID/EX to bubble
//   pipe_hold                  freeze EX/MEM and MEM/WB
//   forward_a/forward_b        ALU operand select (00 reg, 10 EX/MEM, 01 MEM/WB)
//   mem_timeout                sticky: memory wait reached MEM_TIMEOUT cycles
//   stall_count, flush_count   saturating event counters

module hazard_ctrl_unit #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_regwrite,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [WCNT_W-1:0] waitCnt;
  logic [WCNT_W-1:0] waitCntNext;
  logic              memReq;
  logic              memWait;
  logic              loadUse;
  logic              stallInc;
  logic              flushInc;

  assign memReq  = exmem_memread | exmem_memwrite;
  assign memWait = memReq & ~mem_ready;
  assign loadUse = idex_memread && (idex_rd != '0) &&
                   ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  // Next state and stage controls. Priority: wait > branch > load-use > none.
  // While frozen, branch/load-use are ignored; they are seen again once the
  // stages move, since their inputs are held in the frozen buffers.
  always_comb begin
    nextState  = state;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    stallInc   = 1'b0;
    flushInc   = 1'b0;

    case (state)
      RUN:      nextState = memWait ? MEM_WAIT : RUN;
      MEM_WAIT: nextState = memWait ? MEM_WAIT : RUN;
      default:  nextState = RUN;
    endcase

    if (reset) begin
      nextState  = RUN;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (memWait) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      stallInc   = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flushInc   = 1'b1;
    end else if (loadUse) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stallInc   = 1'b1;
    end
  end

  // Wait counter: counts every frozen cycle (saturating), clears on leaving MEM_WAIT.
  always_comb begin
    waitCntNext = waitCnt;
    if (memWait) begin
      if (waitCnt != WAIT_MAX) begin
        waitCntNext = waitCnt + WCNT_W'(1);
      end
    end else if (state == MEM_WAIT) begin
      waitCntNext = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      // Flag rises on the edge where the counter reaches the limit.
      if (memWait && (waitCntNext == WAIT_MAX)) begin
        mem_timeout <= 1'b1;
      end
      if (stallInc && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flushInc && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  function automatic logic [1:0] fwdSel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (exmem_regwrite && !exmem_memread && (exmem_rd != '0) && (exmem_rd == rs)) begin
      sel = 2'b10;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (!reset) begin
      forward_a = fwdSel(idex_rs1);
      forward_b = fwdSel(idex_rs2);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_memread, exmem_regwrite, exmem_memread, exmem_memwrite;
  logic       memwb_regwrite, branch_taken, mem_ready;

  // Instance A: default parameters
  logic        aPcWrite, aIfidWrite, aIfidFlush, aIdexFlush, aHold, aTimeout;
  logic [1:0]  aFwdA, aFwdB;
  logic [15:0] aStall, aFlush;
  // Instance B: narrow counters, short timeout
  logic        bPcWrite, bIfidWrite, bIfidFlush, bIdexFlush, bHold, bTimeout;
  logic [1:0]  bFwdA, bFwdB;
  logic [1:0]  bStall, bFlush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.CNT_W(16), .MEM_TIMEOUT(64)) dutA (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_write(aPcWrite), .ifid_write(aIfidWrite), .ifid_flush(aIfidFlush),
    .idex_flush(aIdexFlush), .pipe_hold(aHold),
    .forward_a(aFwdA), .forward_b(aFwdB), .mem_timeout(aTimeout),
    .stall_count(aStall), .flush_count(aFlush)
  );

  hazard_ctrl_unit #(.CNT_W(2), .MEM_TIMEOUT(4)) dutB (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_write(bPcWrite), .ifid_write(bIfidWrite), .ifid_flush(bIfidFlush),
    .idex_flush(bIdexFlush), .pipe_hold(bHold),
    .forward_a(bFwdA), .forward_b(bFwdB), .mem_timeout(bTimeout),
    .stall_count(bStall), .flush_count(bFlush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
    idex_memread = 1'b0; exmem_rd = '0; exmem_regwrite = 1'b0;
    exmem_memread = 1'b0; exmem_memwrite = 1'b0; memwb_rd = '0;
    memwb_regwrite = 1'b0; branch_taken = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic doReset();
    clearIn();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset outputs, with a forwarding match present that must be masked
    clearIn();
    reset = 1'b1;
    exmem_rd = 5'd7; exmem_regwrite = 1'b1; idex_rs1 = 5'd7;
    #1;
    chk("rst_pc_write",   aPcWrite,   1'b0);
    chk("rst_ifid_write", aIfidWrite, 1'b0);
    chk("rst_ifid_flush", aIfidFlush, 1'b1);
    chk("rst_idex_flush", aIdexFlush, 1'b1);
    chk("rst_pipe_hold",  aHold,      1'b0);
    chk("rst_forward_a",  aFwdA,      2'b00);
    tick();
    chk("rst_stall_count", aStall,   16'd0);
    chk("rst_flush_count", aFlush,   16'd0);
    chk("rst_timeout",     aTimeout, 1'b0);
    clearIn();
    reset = 1'b0;
    #1;
    chk("idle_pc_write",   aPcWrite,   1'b1);
    chk("idle_ifid_write", aIfidWrite, 1'b1);
    chk("idle_idex_flush", aIdexFlush, 1'b0);

    // Load-use on rs2
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5;
    #1;
    chk("lu_pc_write",   aPcWrite,   1'b0);
    chk("lu_ifid_write", aIfidWrite, 1'b0);
    chk("lu_idex_flush", aIdexFlush, 1'b1);
    chk("lu_ifid_flush", aIfidFlush, 1'b0);
    tick();
    chk("lu_stall_count", aStall, 16'd1);
    idex_memread = 1'b0;
    #1;
    chk("lu_release_pc_write", aPcWrite, 1'b1);
    // Load into x0 is never a hazard
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    #1;
    chk("lu_x0_pc_write", aPcWrite, 1'b1);
    tick();
    chk("lu_x0_stall_count", aStall, 16'd1);

    // Branch beats load-use
    doReset();
    branch_taken = 1'b1; idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5;
    #1;
    chk("br_ifid_flush", aIfidFlush, 1'b1);
    chk("br_idex_flush", aIdexFlush, 1'b1);
    chk("br_pc_write",   aPcWrite,   1'b1);
    chk("br_ifid_write", aIfidWrite, 1'b1);
    tick();
    chk("br_flush_count", aFlush, 16'd1);
    chk("br_stall_count", aStall, 16'd0);

    // Three-cycle memory wait, with a branch pending that must be ignored
    doReset();
    exmem_memread = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("mw_pipe_hold",  aHold,      1'b1);
      chk("mw_pc_write",   aPcWrite,   1'b0);
      chk("mw_ifid_flush", aIfidFlush, 1'b0);
      tick();
    end
    chk("mw_stall_count", aStall, 16'd3);
    mem_ready = 1'b1; branch_taken = 1'b0;
    #1;
    chk("mw_done_pc_write",  aPcWrite, 1'b1);
    chk("mw_done_pipe_hold", aHold,    1'b0);
    tick();
    chk("mw_done_flush_count", aFlush,   16'd0);
    chk("mw_done_stall_count", aStall,   16'd3);
    chk("mw_b_no_timeout",     bTimeout, 1'b0);

    // Timeout: six wait cycles on B (limit 4), A (limit 64) must stay clear
    doReset();
    exmem_memwrite = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) chk("to_b_before", bTimeout, 1'b0);
      if (i == 4) chk("to_b_at4", bTimeout, 1'b1);
    end
    chk("to_a_clear",     aTimeout, 1'b0);
    chk("to_a_stall",     aStall,   16'd6);
    chk("to_b_stall_sat", bStall,   2'd3);
    chk("to_b_hold",      bHold,    1'b1);
    mem_ready = 1'b1;
    #1;
    chk("to_ready_pc_write", bPcWrite, 1'b1);
    tick();
    chk("to_sticky1", bTimeout, 1'b1);
    exmem_memwrite = 1'b0;
    tick();
    chk("to_sticky2", bTimeout, 1'b1);

    // Reset in the middle of a wait clears timeout and the wait counter
    exmem_memwrite = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rmw_timeout_clr", bTimeout, 1'b0);
    chk("rmw_stall_clr",   bStall,   2'd0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    chk("rmw_after3", bTimeout, 1'b0);
    tick();
    chk("rmw_after4", bTimeout, 1'b1);

    // Forwarding
    doReset();
    exmem_rd = 5'd7; exmem_regwrite = 1'b1; memwb_rd = 5'd7; memwb_regwrite = 1'b1;
    idex_rs1 = 5'd7;
    #1;
    chk("fwd_a_exmem", aFwdA, 2'b10);
    exmem_rd = 5'd0;
    #1;
    chk("fwd_a_memwb", aFwdA, 2'b01);
    idex_rs1 = 5'd0; memwb_rd = 5'd0;
    #1;
    chk("fwd_a_x0", aFwdA, 2'b00);
    exmem_rd = 5'd9; exmem_memread = 1'b1; memwb_rd = 5'd9; idex_rs2 = 5'd9;
    #1;
    chk("fwd_b_load_skips_exmem", aFwdB, 2'b01);
    exmem_memread = 1'b0;
    #1;
    chk("fwd_b_exmem", bFwdB, 2'b10);
    idex_rs2 = 5'd8;
    #1;
    chk("fwd_b_nomatch", aFwdB, 2'b00);

    // Counter saturation: five load-use stall cycles
    doReset();
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 3) chk("sat_b_at3", bStall, 2'd3);
    end
    chk("sat_b_at5", bStall, 2'd3);
    chk("sat_a_at5", aStall, 16'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
